// File: rtl/cpu_pkg.sv
// Shared constants and types for the RV32I pipeline: opcodes, bubble word,
// fetch FSM encoding and the IF/ID pipeline record.
package cpu_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    FS_RUN  = 2'd0,
    FS_MISS = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/jal_predecode.sv
// Combinational JAL detector and J-immediate extractor used for
// fetch-time jump prediction.
module jal_predecode
  import cpu_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [19:0] i_upper,   // instr[31:12]
  output logic        o_is_jal,
  output logic [31:0] o_imm
);

  assign o_is_jal = (i_opcode == OP_JAL);

  // J-immediate {i[31], i[19:12], i[20], i[30:21], 0}, indices relative to instr[12]
  assign o_imm = {{11{i_upper[19]}}, i_upper[19], i_upper[7:0], i_upper[8],
                  i_upper[18:9], 1'b0};

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, I-cache request and IF/ID register, with
// miss/stall/redirect handling. Optional JAL predecode under JAL_PREDECODE_EN.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        ic_req_o,
  output logic [29:0] ic_addr_o,
  input  logic        ic_stall_i,
  input  logic [31:0] ic_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] ST_RUN  = FS_RUN;
  localparam logic [1:0] ST_MISS = FS_MISS;
  localparam logic [1:0] ST_DROP = FS_DROP;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  if_id_t      r_ifid;

  logic [1:0]  w_state_n;
  logic [31:0] w_pc_n;
  logic [31:0] w_target_n;
  if_id_t      w_ifid_n;
  if_id_t      w_bubble;
  logic [31:0] w_redir_tgt;
  logic [31:0] w_seq_pc;
  logic        w_take_jal;
  logic [31:0] w_jal_imm;

`ifdef JAL_PREDECODE_EN
  jal_predecode u_jal_predecode (
    .i_opcode (ic_rdata_i[6:0]),
    .i_upper  (ic_rdata_i[31:12]),
    .o_is_jal (w_take_jal),
    .o_imm    (w_jal_imm)
  );
`else
  assign w_take_jal = 1'b0;
  assign w_jal_imm  = 32'd0;
`endif

  assign w_redir_tgt = redirect_pc_i & 32'hFFFF_FFFC;
  assign w_bubble    = {1'b0, r_ifid.pc, NOP_INSTR};
  assign w_seq_pc    = w_take_jal ? (r_pc + w_jal_imm) : (r_pc + 32'd4);

  always_comb begin
    w_state_n  = r_state;
    w_pc_n     = r_pc;
    w_target_n = r_target;
    w_ifid_n   = r_ifid;
    case (r_state)
      ST_DROP: begin
        // The redirect already flushed ID; whatever the cache returns is stale.
        w_ifid_n = w_bubble;
        if (redirect_i) w_target_n = w_redir_tgt;
        if (!ic_stall_i) begin
          w_pc_n    = redirect_i ? w_redir_tgt : r_target;
          w_state_n = ST_RUN;
        end
      end
      default: begin
        // RUN and the exit cycle of MISS behave identically.
        if (redirect_i) begin
          w_ifid_n = w_bubble;
          if (ic_stall_i) begin
            w_target_n = w_redir_tgt;
            w_state_n  = ST_DROP;
          end else begin
            w_pc_n    = w_redir_tgt;
            w_state_n = ST_RUN;
          end
        end else if (ic_stall_i) begin
          w_state_n = ST_MISS;
          if (!stall_i) w_ifid_n = w_bubble;
        end else if (!stall_i) begin
          w_ifid_n  = {1'b1, r_pc, ic_rdata_i};
          w_pc_n    = w_seq_pc;
          w_state_n = ST_RUN;
        end else begin
          w_state_n = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_PC;
      r_target <= RESET_PC;
      r_ifid   <= {1'b0, 32'h0000_0000, NOP_INSTR};
    end else begin
      r_state  <= w_state_n;
      r_pc     <= w_pc_n;
      r_target <= w_target_n;
      r_ifid   <= w_ifid_n;
    end
  end

  assign ic_req_o    = rst_n_i;
  assign ic_addr_o   = r_pc[31:2];
  assign id_valid_o  = r_ifid.valid;
  assign id_pc_o     = r_ifid.pc;
  assign id_instr_o  = r_ifid.instr;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage, plus hand sequences for
// double redirect during a miss and reset during a miss.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req;
  logic [29:0] ic_addr;
  logic        ic_stall;
  logic [31:0] ic_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef JAL_PREDECODE_EN
  localparam logic [31:0] JAL_NEXT = 32'h0000_0050;
`else
  localparam logic [31:0] JAL_NEXT = 32'h0000_0044;
`endif

  fetch_stage dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .ic_req_o     (ic_req),
    .ic_addr_o    (ic_addr),
    .ic_stall_i   (ic_stall),
    .ic_rdata_i   (ic_rdata),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .id_valid_o   (id_valid),
    .id_pc_o      (id_pc),
    .id_instr_o   (id_instr),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary, required finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        ics;
    logic        stl;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] rdata;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic [31:0] enext;   // expected PC after the edge
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] iw(input logic [31:0] a);
    return {8'hA5, a[15:0], 8'h13};
  endfunction

  task automatic put(input logic ics, input logic stl, input logic rd,
                     input logic [31:0] rpc, input logic [31:0] rdata,
                     input logic ev, input logic [31:0] epc,
                     input logic [31:0] ei, input logic [31:0] enext);
    vec_t v;
    v.ics = ics; v.stl = stl; v.rd = rd; v.rpc = rpc; v.rdata = rdata;
    v.ev = ev; v.epc = epc; v.ei = ei; v.enext = enext;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ics, input logic stl, input logic rd,
                       input logic [31:0] rpc, input logic [31:0] rdata);
    ic_stall = ics; stall = stl; redirect = rd; redirect_pc = rpc; ic_rdata = rdata;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [29:0] held;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // ---- vector table: inputs for one cycle, IF/ID and next address after the edge
    put(0,0,0,32'h0, iw(32'h00),    1, 32'h00, iw(32'h00), 32'h04);
    put(0,0,0,32'h0, iw(32'h04),    1, 32'h04, iw(32'h04), 32'h08);
    put(0,0,0,32'h0, iw(32'h08),    1, 32'h08, iw(32'h08), 32'h0C);
    for (int k = 0; k < 3; k++)
      put(0,1,0,32'h0, iw(32'h0C),  1, 32'h08, iw(32'h08), 32'h0C);
    put(0,0,0,32'h0, iw(32'h0C),    1, 32'h0C, iw(32'h0C), 32'h10);
    for (int k = 0; k < 5; k++)
      put(1,0,0,32'h0, 32'hDEADBEEF,0, 32'h0C, NOP_INSTR,  32'h10);
    put(0,0,0,32'h0, iw(32'h10),    1, 32'h10, iw(32'h10), 32'h14);
    put(0,0,0,32'h0, iw(32'h14),    1, 32'h14, iw(32'h14), 32'h18);
    put(0,0,0,32'h0, iw(32'h18),    1, 32'h18, iw(32'h18), 32'h1C);
    put(0,0,0,32'h0, iw(32'h1C),    1, 32'h1C, iw(32'h1C), 32'h20);
    put(1,0,0,32'h0, 32'hDEADBEEF,  0, 32'h1C, NOP_INSTR,  32'h20);
    put(1,0,1,32'h100, 32'hDEADBEEF,0, 32'h1C, NOP_INSTR,  32'h20);
    put(1,0,0,32'h0, 32'hDEADBEEF,  0, 32'h1C, NOP_INSTR,  32'h20);
    put(0,0,0,32'h0, iw(32'h20),    0, 32'h1C, NOP_INSTR,  32'h100);
    put(0,0,0,32'h0, iw(32'h100),   1, 32'h100, iw(32'h100), 32'h104);
    put(0,1,1,32'h203, iw(32'h104), 0, 32'h100, NOP_INSTR, 32'h200);
    put(0,0,0,32'h0, iw(32'h200),   1, 32'h200, iw(32'h200), 32'h204);
    put(0,0,1,32'hFFFF_FFFC, iw(32'h204), 0, 32'h200, NOP_INSTR, 32'hFFFF_FFFC);
    put(0,0,0,32'h0, iw(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, iw(32'hFFFF_FFFC), 32'h0);
    put(0,0,0,32'h0, iw(32'h0),     1, 32'h0, iw(32'h0), 32'h4);
    put(0,0,1,32'h40, iw(32'h4),    0, 32'h0, NOP_INSTR, 32'h40);
    put(0,0,0,32'h0, 32'h0100_006F, 1, 32'h40, 32'h0100_006F, JAL_NEXT);
    put(0,0,0,32'h0, iw(JAL_NEXT),  1, JAL_NEXT, iw(JAL_NEXT), JAL_NEXT + 32'd4);

    // ---- reset state
    #12;
    chk("rst_req", {31'd0, ic_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, NOP_INSTR);
    chk("rst_addr", {2'b00, ic_addr}, 32'h0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("req_after_rst", {31'd0, ic_req}, 32'd1);

    foreach (vq[i]) begin
      drive(vq[i].ics, vq[i].stl, vq[i].rd, vq[i].rpc, vq[i].rdata);
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, id_valid}, {31'd0, vq[i].ev});
      chk($sformatf("v%0d_pc", i), id_pc, vq[i].epc);
      chk($sformatf("v%0d_instr", i), id_instr, vq[i].ei);
      chk($sformatf("v%0d_addr", i), {2'b00, ic_addr}, {2'b00, vq[i].enext[31:2]});
    end

    // ---- two redirects during a miss: last target wins
    held = (JAL_NEXT + 32'd4) >> 2;
    drive(1, 0, 0, 32'h0, 32'hDEADBEEF);
    tick();
    chk("miss_state", {30'd0, dbg_state}, 32'd1);
    drive(1, 0, 1, 32'h300, 32'hDEADBEEF);
    tick();
    chk("drop_state", {30'd0, dbg_state}, 32'd2);
    chk("drop_addr1", {2'b00, ic_addr}, {2'b00, held});
    drive(1, 0, 1, 32'h400, 32'hDEADBEEF);
    tick();
    chk("drop_addr2", {2'b00, ic_addr}, {2'b00, held});
    chk("drop_valid", {31'd0, id_valid}, 32'd0);
    drive(0, 0, 0, 32'h0, 32'hDEADBEEF);
    tick();
    chk("drop_exit_addr", {2'b00, ic_addr}, 32'h100);
    chk("drop_exit_valid", {31'd0, id_valid}, 32'd0);
    chk("drop_exit_state", {30'd0, dbg_state}, 32'd0);
    drive(0, 0, 0, 32'h0, iw(32'h400));
    tick();
    chk("after_drop_pc", id_pc, 32'h400);
    chk("after_drop_valid", {31'd0, id_valid}, 32'd1);
    chk("after_drop_instr", id_instr, iw(32'h400));

    // ---- reset in the middle of a miss aborts immediately
    drive(1, 0, 0, 32'h0, 32'hDEADBEEF);
    tick();
    chk("pre_rst_state", {30'd0, dbg_state}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_req", {31'd0, ic_req}, 32'd0);
    chk("mrst_addr", {2'b00, ic_addr}, 32'h0);
    chk("mrst_state", {30'd0, dbg_state}, 32'd0);
    chk("mrst_instr", id_instr, NOP_INSTR);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 32'h0, iw(32'h0));
    tick();
    chk("mrst_first_pc", id_pc, 32'h0);
    chk("mrst_first_valid", {31'd0, id_valid}, 32'd1);
    chk("mrst_first_addr", {2'b00, ic_addr}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
